bla_subtractor_seq: RTL and testbench
=====================================

// Module: bla_subtractor_seq
// PURPOSE
// Multi-cycle WIDTH-bit subtractor: computes DIFF = A - B - BIN, 4 bits per clock,
// using a 4-bit borrow-lookahead slice with the borrow carried between cycles.
// Complement block to the 4-bit carry-lookahead adder.
// Operands arrive on a valid/ready input handshake; results leave on a valid/ready output handshake.
// Provides a borrow-out plus zero and signed-overflow flags for datapath compare/decrement use.
// PARAMETERS
// WIDTH  16  operand/result width in bits; must be a multiple of 4 and >= 4 (NIB = WIDTH/4)
// PORTS
// clk        in   1      clock, rising edge
// rst        in   1      asynchronous reset, active-high
// in_valid   in   1      a/b/bin valid
// in_ready   out  1      block can accept operands (high only in IDLE)
// a          in   WIDTH  minuend
// b          in   WIDTH  subtrahend
// bin        in   1      borrow in
// out_valid  out  1      diff/bout/zero/ovf valid (high only in DONE)
// out_ready  in   1      downstream accepts result
// diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
// bout       out  1      unsigned borrow out (1 iff a < b + bin)
// zero       out  1      diff == 0
// ovf        out  1      two's-complement overflow of a - b - bin
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, nibble counter=0, internal borrow=0;
//   diff=0, bout=0, zero=0, ovf=0, out_valid=0, in_ready=0 while rst is high.
// - All outputs are registered except in_ready = (state==IDLE) & ~rst.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE -> RUN on in_valid & in_ready:
//     - capture a, b and bin into the borrow register
//     - counter=0
//     - clear the diff register
//   - RUN: at each edge, process nibble k=counter (bits 4k+3:4k):
//     - p=~(a^b), g=~a&b
//     - lookahead borrows: c0 = g0|p0&br, c1 = g1|p1&g0|p1&p0&br, ... (full 4-level expansion)
//     - d = a^b^{c2,c1,c0,br}
//     - write d into diff[4k+3:4k]; br <= c3; counter++
//   - RUN -> DONE on the edge processing nibble NIB-1. On that edge, register:
//     - bout = c3
//     - zero = (full diff == 0)
//     - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB])
//   - DONE: out_valid=1. diff, bout, zero and ovf are held stable until the handshake completes.
//   - DONE -> IDLE on out_valid & out_ready; out_valid drops at that edge.
// - Latency: operands accepted at edge E; out_valid high from edge E+NIB onward.
//   Minimum throughput: one result every NIB+2 cycles.
// - in_ready=0 in RUN and DONE; in_valid is ignored there. Captured operands are unaffected
//   by input changes after acceptance.
// - No accept in the same cycle as out handshake: a new operand is accepted at the earliest
//   one cycle after DONE -> IDLE.
// - zero/ovf/bout are valid only while out_valid=1. They keep the last result after DONE -> IDLE
//   and are cleared when the next operands are accepted.
// - Reset mid-operation (RUN or DONE): the operation is aborted, no result is produced,
//   and all outputs return to their reset values.
// - WIDTH=4 (NIB=1): RUN lasts exactly one cycle.
// TESTING
// 1. WIDTH=16, a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, zero=0, ovf=0;
//    out_valid exactly 4 cycles after accept.
// 2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0, zero=0
//    (borrow ripples through all 4 nibbles).
// 3. a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, ovf=1, bout=0; a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, bout=1.
// 4. a=0x5555, b=0x5554, bin=1 -> diff=0x0000, zero=1, bout=0, ovf=0.
// 5. Hold out_ready=0 for 6 cycles in DONE while toggling in_valid and a/b ->
//    out_valid and result stay constant, in_ready=0; release -> IDLE, next op accepted a cycle later.
// 6. Assert rst on the 2nd RUN cycle -> all outputs 0 and IDLE immediately;
//    then a random op vs a golden (a-b-bin) model matches. Follow with 1000 random ops
//    including back-to-back traffic.

Source files
------------

// File: rtl/bla_subtractor_seq.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one nibble per clock
// through a 4-bit borrow-lookahead slice, with the borrow carried between cycles.
// Valid/ready handshakes on both the operand and the result side.

// 4-bit borrow-lookahead slice: fully expanded borrow chain, no ripple.
module bla_slice4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bi,
   output logic [3:0] d,
   output logic       bo
);
   logic [3:0] p, g;
   logic       c0, c1, c2, c3;

   // Propagate/generate, lookahead borrows and difference bits.
   always_comb begin
      p  = ~(a ^ b);
      g  = ~a & b;
      c0 = g[0] | (p[0] & bi);
      c1 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
      c2 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
      c3 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & bi);
      d  = a ^ b ^ {c2, c1, c0, bi};
      bo = c3;
   end
endmodule

module bla_subtractor_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);
   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, nstate;
   logic [WIDTH-1:0] a_q, b_q;
   logic             br;
   logic [CW-1:0]    cnt;
   logic [CW+1:0]    base;
   logic [3:0]       nib_a, nib_b, nib_d;
   logic             c3;
   logic [WIDTH-1:0] diff_nxt;
   logic             accept, last;

   // Current nibble of the captured operands and the diff with it merged in;
   // the merged value lets zero/ovf be registered on the final RUN edge.
   always_comb begin
      base     = {cnt, 2'b00};
      nib_a    = a_q[base +: 4];
      nib_b    = b_q[base +: 4];
      diff_nxt = diff;
      diff_nxt[base +: 4] = nib_d;
      last     = (cnt == LAST);
      accept   = in_valid & in_ready;
   end

   bla_slice4 u_slice (
      .a  (nib_a),
      .b  (nib_b),
      .bi (br),
      .d  (nib_d),
      .bo (c3)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   // Next-state logic.
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (accept)    nstate = RUN;
         RUN:     if (last)      nstate = DONE;
         DONE:    if (out_ready) nstate = IDLE;
         default:                nstate = IDLE;
      endcase
   end

   // Only in_ready is combinational; it is forced low while reset is held.
   always_comb begin
      in_ready = (state == IDLE) & ~rst;
   end

   // Datapath: operand capture, per-nibble result write, flags on the last nibble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         br        <= 1'b0;
         cnt       <= '0;
         diff      <= '0;
         bout      <= 1'b0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               a_q  <= a;
               b_q  <= b;
               br   <= bin;
               cnt  <= '0;
               diff <= '0;
               bout <= 1'b0;
               zero <= 1'b0;
               ovf  <= 1'b0;
            end
            RUN: begin
               diff <= diff_nxt;
               br   <= c3;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  bout      <= c3;
                  zero      <= (diff_nxt == '0);
                  ovf       <= (a_q[MSB] ^ b_q[MSB]) & (diff_nxt[MSB] ^ a_q[MSB]);
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bla_subtractor_seq.sv
// Directed bench for bla_subtractor_seq (WIDTH=16), plus a golden-model sweep.
module tb_bla_subtractor_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, bin, out_valid, out_ready;
   logic [15:0] a, b, diff;
   logic        bout, zero, ovf;
   int          checks = 0;
   int          failures = 0;

   bla_subtractor_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait for out_valid (bounded) and return the cycle count.
   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   // One full transaction: accept, scramble inputs, check latency/result, handshake.
   task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                         input logic [15:0] ed, input logic eb, input logic ez,
                         input logic eo, input string tag);
      int n;
      a = va; b = vb; bin = vbin; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      chk({tag, "_flags_cleared"}, {29'd0, bout, zero, ovf}, 32'd0);
      wait_out(n);
      chk({tag, "_latency"}, 32'(n), 32'd4);
      chk({tag, "_diff"}, 32'(diff), 32'(ed));
      chk({tag, "_bout"}, 32'(bout), 32'(eb));
      chk({tag, "_zero"}, 32'(zero), 32'(ez));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int          n;
      logic [16:0] full;
      logic [15:0] ra, rb, ed;
      logic        rbin, eo;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
      tick();
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_bout", 32'(bout), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      tick();

      run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, "v1");
      run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, "v2_ripple");
      run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, "v3_ovf_neg");
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, "v3_ovf_pos");
      run_op(16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, "v4_zero");
      run_op(16'h0003, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, "v4b_after_zero");
      run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, "bin_only");

      // Backpressure: hold the result while inputs toggle.
      a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1;
      chk("bp_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      wait_out(n);
      chk("bp_latency", 32'(n), 32'd4);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'(i & 1); a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
         tick();
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_diff", {15'd0, bout, diff}, 32'h0_1000);
         chk("bp_hold_flags", {30'd0, zero, ovf}, 32'd0);
         chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      a = 16'h0005; b = 16'h0003; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("bp_next_accepted", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      wait_out(n);
      chk("bp_next_latency", 32'(n), 32'd4);
      chk("bp_next_diff", 32'(diff), 32'h0002);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset during the second RUN cycle.
      a = 16'h00FF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_diff", 32'(diff), 32'd0);
      chk("midrst_flags", {29'd0, bout, zero, ovf}, 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("midrst_idle", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("midrst_no_result", 32'(out_valid), 32'd0);
      end

      // Golden-model sweep, back-to-back operands.
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
         if (i % 10 == 0) rb = ra;
         full = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
         ed   = full[15:0];
         eo   = (ra[15] != rb[15]) && (ed[15] != ra[15]);
         run_op(ra, rb, rbin, ed, full[16], (ed == 16'd0), eo, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
